// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A single borrow flop replaces the ripple chain; operands and results use ready/valid.
module serial_subtractor #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          brw_q, brw_d;
    logic          amsb_q, amsb_d;
    logic          bmsb_q, bmsb_d;
    logic          brw_out_q, brw_out_d;
    logic          zero_q, zero_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;

    logic ai, bi, di, brw_nxt;
    logic [N-1:0] res_shift;

    assign ai        = a_sh_q[0];
    assign bi        = b_sh_q[0];
    assign di        = ai ^ bi ^ brw_q;
    assign brw_nxt   = (~ai & bi) | (~(ai ^ bi) & brw_q);
    // New bit enters at the MSB so the first (LSB) bit lands in bit 0 after N shifts.
    assign res_shift = {di, res_q[N-1:1]};

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign diff       = res_q;
    assign borrow_out = brw_out_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign overflow   = ovf_q;

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        brw_d     = brw_q;
        amsb_d    = amsb_q;
        bmsb_d    = bmsb_q;
        brw_out_d = brw_out_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    amsb_d  = a[N-1];
                    bmsb_d  = b[N-1];
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shift;
                brw_d  = brw_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    // Flags come from the completed result, not the partial register.
                    brw_out_d = brw_nxt;
                    zero_d    = (res_shift == '0);
                    neg_d     = di;
                    ovf_d     = (amsb_q ^ bmsb_q) & (di ^ amsb_q);
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            brw_q     <= 1'b0;
            amsb_q    <= 1'b0;
            bmsb_q    <= 1'b0;
            brw_out_q <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            brw_q     <= brw_d;
            amsb_q    <= amsb_d;
            bmsb_q    <= bmsb_d;
            brw_out_q <= brw_out_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule
